// File: rtl/systolic_feed_sequencer.sv
// Systolic feed sequencer: streams one 4x4 A/W tile pair into the MAC array.
// Optional completed-pass counter enabled by defining SEQ_TILE_COUNT_EN.
module systolic_feed_sequencer #(
  parameter int DW           = 8,
  parameter int DRAIN_CYCLES = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [1:0]    ld_row,
  input  logic [4*DW-1:0] ld_data,
  output logic [DW-1:0] a_row0,
  output logic [DW-1:0] a_row1,
  output logic [DW-1:0] a_row2,
  output logic [DW-1:0] a_row3,
  output logic [DW-1:0] w_col0,
  output logic [DW-1:0] w_col1,
  output logic [DW-1:0] w_col2,
  output logic [DW-1:0] w_col3,
  output logic          array_wen,
  output logic          array_run,
  output logic          busy,
  output logic          done,
  output logic          ld_err,
  output logic [4:0]    step_cnt,
  output logic [15:0]   tile_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [4:0] FEED_LAST  = 5'd6;
  localparam logic [4:0] DRAIN_LAST = 5'(6 + DRAIN_CYCLES);

  state_t state_q, state_d;
  logic [4:0] step_q, step_d;
  logic [3:0][3:0][DW-1:0] a_q, a_d;
  logic [3:0][3:0][DW-1:0] w_q, w_d;
  logic [3:0][DW-1:0] af_q, af_d;
  logic [3:0][DW-1:0] wf_q, wf_d;
  logic wen_q, wen_d;
  logic run_q, run_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic feed_on;

  // Tile write path; the next-tile value also feeds step 0 on a same-edge load.
  always_comb begin
    a_d = a_q;
    w_d = w_q;
    if (state_q == S_IDLE && ld_en) begin
      if (ld_sel) w_d[ld_row] = ld_data;
      else        a_d[ld_row] = ld_data;
    end
  end

  // Pass sequencing: next state, step index and array controls.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wen_d   = 1'b0;
    run_d   = 1'b0;
    done_d  = 1'b0;
    feed_on = 1'b0;
    err_d   = ld_en && (state_q != S_IDLE);
    if (abort) begin
      state_d = S_IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          step_d = '0;
          if (start) begin
            state_d = S_FEED;
            feed_on = 1'b1;
            wen_d   = 1'b1;
            run_d   = 1'b1;
          end
        end
        S_FEED: begin
          run_d  = 1'b1;
          step_d = step_q + 5'd1;
          if (step_q == FEED_LAST) begin
            state_d = S_DRAIN;
          end else begin
            feed_on = 1'b1;
            wen_d   = 1'b1;
          end
        end
        S_DRAIN: begin
          run_d  = 1'b1;
          step_d = step_q + 5'd1;
          if (step_q == DRAIN_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          step_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Skewed diagonal select: element (i,k) enters at step i+k.
  always_comb begin
    af_d = '0;
    wf_d = '0;
    if (feed_on) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (int'(step_d) == i + k) begin
            af_d[i] = a_d[i][k];
            wf_d[i] = w_d[k][i];
          end
        end
      end
    end
  end

  // State, tile storage and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      w_q     <= '0;
      af_q    <= '0;
      wf_q    <= '0;
      wen_q   <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      w_q     <= w_d;
      af_q    <= af_d;
      wf_q    <= wf_d;
      wen_q   <= wen_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef SEQ_TILE_COUNT_EN
  logic [15:0] cnt_q;

  // Completed-pass counter, bumped at the end of each DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt_q <= '0;
    else if (state_q == S_DONE)  cnt_q <= cnt_q + 16'd1;
  end

  assign tile_count = cnt_q;
`else
  assign tile_count = '0;
`endif

  assign a_row0    = af_q[0];
  assign a_row1    = af_q[1];
  assign a_row2    = af_q[2];
  assign a_row3    = af_q[3];
  assign w_col0    = wf_q[0];
  assign w_col1    = wf_q[1];
  assign w_col2    = wf_q[2];
  assign w_col3    = wf_q[3];
  assign array_wen = wen_q;
  assign array_run = run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ld_err    = err_q;
  assign step_cnt  = step_q;

endmodule
